// File: rtl/led_breath_driver.sv
`timescale 1ns/1ps
// led_breath_driver: turns a slow-domain LED on/off request into a breathing
// PWM output. The request is synchronised through two flops. A four-state FSM
// (OFF/RISE/ON/FALL) ramps a duty value one step per STEP_CYCLES clocks. A
// free-running PWM counter compares against a shadow copy of the duty value,
// and the shadow copy is reloaded only at the start of each PWM period.
module led_breath_driver #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 390625,
  parameter int unsigned MAX_DUTY    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                led_req,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int unsigned         STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(MAX_DUTY);
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RISE = 2'd1,
    S_ON   = 2'd2,
    S_FALL = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic                pwm_q, pwm_d;
  logic                busy_q, busy_d;

  logic level;
  logic step_tick;

  assign level     = sync2_q;
  assign step_tick = (step_q == STEP_LAST);

  // Two-flop synchroniser chain for the asynchronous request.
  always_comb begin
    sync1_d = led_req;
    sync2_d = sync1_q;
  end

  // Ramp FSM. A level change wins over a coincident step tick and leaves the
  // duty untouched. The end-of-ramp tests use >= / <= so that a reversal taken
  // at the extreme duty value (e.g. FALL entered at 0) can never wrap.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    step_d  = '0;
    unique case (state_q)
      S_OFF: begin
        if (level) state_d = S_RISE;
      end
      S_RISE: begin
        if (!level) begin
          state_d = S_FALL;
        end else begin
          step_d = step_tick ? '0 : (step_q + STEP_ONE);
          if (step_tick) begin
            if (duty_q >= (DUTY_MAX - DUTY_ONE)) begin
              duty_d  = DUTY_MAX;
              state_d = S_ON;
            end else begin
              duty_d = duty_q + DUTY_ONE;
            end
          end
        end
      end
      S_ON: begin
        if (!level) state_d = S_FALL;
      end
      S_FALL: begin
        if (level) begin
          state_d = S_RISE;
        end else begin
          step_d = step_tick ? '0 : (step_q + STEP_ONE);
          if (step_tick) begin
            if (duty_q <= DUTY_ONE) begin
              duty_d  = '0;
              state_d = S_OFF;
            end else begin
              duty_d = duty_q - DUTY_ONE;
            end
          end
        end
      end
      default: begin
        state_d = S_OFF;
        duty_d  = '0;
      end
    endcase
    busy_d = (state_d == S_RISE) || (state_d == S_FALL);
  end

  // PWM counter and shadow. The output is computed from next-state values so
  // that the registered pwm_out lines up with the registered counter value.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + DUTY_ONE;
    shadow_d  = (pwm_cnt_q == '1) ? duty_q : shadow_q;
    pwm_d     = (state_d == S_ON) || (pwm_cnt_d < shadow_d);
  end

  // State registers, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_OFF;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      step_q    <= '0;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      shadow_q  <= '0;
      pwm_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      step_q    <= step_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      shadow_q  <= shadow_d;
      pwm_q     <= pwm_d;
      busy_q    <= busy_d;
    end
  end

  assign pwm_out = pwm_q;
  assign duty    = duty_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_breath_driver.sv
`timescale 1ns/1ps
// Directed bench for led_breath_driver. Two instances share clk and reset:
// dut (STEP_CYCLES=2) for ramp/reversal timing, and u_slow (STEP_CYCLES=1000)
// for PWM waveform shape and shadow-update checks.
module tb_led_breath_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       led_req;
  logic       led_req_s;
  logic       pwm_out, busy;
  logic [3:0] duty;
  logic       pwm_s, busy_s;
  logic [3:0] duty_s;

  int tests  = 0;
  int fails  = 0;
  int edge_n = 0;
  int e0     = 0;
  int exp_d  = 0;
  int exp_b  = 0;
  int rev_tab [35] = '{0,0,0,0,1,1,2,2,3,3,4,4,5,5,6,6,
                       7,7,7,6,6,5,5,4,4,3,3,3,3,4,4,5,5,6,6};

  always #5 clk = ~clk;

  led_breath_driver #(.PWM_BITS(4), .STEP_CYCLES(2), .MAX_DUTY(15)) dut (
    .clk(clk), .reset(reset), .led_req(led_req),
    .pwm_out(pwm_out), .duty(duty), .busy(busy)
  );

  led_breath_driver #(.PWM_BITS(4), .STEP_CYCLES(1000), .MAX_DUTY(15)) u_slow (
    .clk(clk), .reset(reset), .led_req(led_req_s),
    .pwm_out(pwm_s), .duty(duty_s), .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic run_until(input int target);
    while (edge_n < target) tick();
  endtask

  initial begin
    reset     = 1'b1;
    led_req   = 1'b1;
    led_req_s = 1'b1;
    #1;

    // Reset held with the request high
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("rst_pwm[%0d]", i), pwm_out, 0);
      chk($sformatf("rst_duty[%0d]", i), duty, 0);
      chk($sformatf("rst_busy[%0d]", i), busy, 0);
    end
    chk("rst_slow_duty", duty_s, 0);

    reset     = 1'b0;
    led_req   = 1'b0;
    led_req_s = 1'b0;
    edge_n    = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("idle_pwm[%0d]", i), pwm_out, 0);
      chk($sformatf("idle_duty[%0d]", i), duty, 0);
      chk($sformatf("idle_busy[%0d]", i), busy, 0);
    end

    // Ramp up from OFF to ON
    led_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_d = (i < 2) ? 0 : (((i - 2) / 2 > 15) ? 15 : (i - 2) / 2);
      exp_b = (i >= 2 && i < 32) ? 1 : 0;
      chk($sformatf("up_duty[%0d]", i), duty, exp_d);
      chk($sformatf("up_busy[%0d]", i), busy, exp_b);
      if (i >= 32) chk($sformatf("up_pwm_on[%0d]", i), pwm_out, 1);
    end

    // Full fall from ON to OFF
    led_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      exp_d = (i < 2) ? 15 : ((i >= 32) ? 0 : 15 - (i - 2) / 2);
      exp_b = (i >= 2 && i < 32) ? 1 : 0;
      chk($sformatf("dn_duty[%0d]", i), duty, exp_d);
      chk($sformatf("dn_busy[%0d]", i), busy, exp_b);
      if (i < 2)   chk($sformatf("dn_pwm_on[%0d]", i), pwm_out, 1);
      if (i >= 50) chk($sformatf("dn_pwm_off[%0d]", i), pwm_out, 0);
    end

    // Reversals: RISE->FALL holding 7, then FALL->RISE at 3 on a step-tick clock
    led_req = 1'b1;
    for (int i = 0; i < 35; i++) begin
      tick();
      chk($sformatf("rev_duty[%0d]", i), duty, rev_tab[i]);
      chk($sformatf("rev_busy[%0d]", i), busy, (i >= 2) ? 1 : 0);
      if (i == 14) led_req = 1'b0;
      if (i == 24) led_req = 1'b1;
    end
    led_req = 1'b0;
    repeat (40) tick();
    chk("rev_end_duty", duty, 0);
    chk("rev_end_busy", busy, 0);
    led_req = 1'b1;

    // Slow instance: align RISE entry to PWM counter 0 (edge_n mod 16 == 0)
    while ((edge_n % 16) != 13) tick();
    led_req_s = 1'b1;
    e0 = edge_n + 3;
    run_until(e0 - 1);
    chk("slow_busy_pre", busy_s, 0);
    tick();
    chk("slow_busy_entry", busy_s, 1);
    chk("slow_duty_entry", duty_s, 0);
    run_until(e0 + 999);
    chk("slow_duty_999", duty_s, 0);
    tick();
    chk("slow_duty_1000", duty_s, 1);
    run_until(e0 + 4999);
    chk("slow_duty_4999", duty_s, 4);
    tick();
    chk("slow_duty_5000", duty_s, 5);

    // Full period with shadow 5: high on counter 0..4 only
    run_until(e0 + 5007);
    for (int j = 0; j < 16; j++) begin
      tick();
      chk($sformatf("shape5_pwm[%0d]", j), pwm_s, (j < 5) ? 1 : 0);
    end

    // Duty moves 8->9 at counter 8; pattern keeps shadow 8 until the next wrap
    run_until(e0 + 8991);
    for (int j = 0; j < 32; j++) begin
      tick();
      chk($sformatf("shadow_pwm[%0d]", j), pwm_s, (j < 16) ? ((j < 8) ? 1 : 0) : ((j - 16 < 9) ? 1 : 0));
      if (j == 8) chk("shadow_duty_mid", duty_s, 9);
    end

    // Asynchronous reset between clock edges
    chk("pre_rst_main_duty", duty, 15);
    chk("pre_rst_main_pwm", pwm_out, 1);
    chk("pre_rst_slow_duty", duty_s, 9);
    chk("pre_rst_slow_busy", busy_s, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_main_pwm", pwm_out, 0);
    chk("arst_main_duty", duty, 0);
    chk("arst_main_busy", busy, 0);
    chk("arst_slow_pwm", pwm_s, 0);
    chk("arst_slow_duty", duty_s, 0);
    chk("arst_slow_busy", busy_s, 0);
    led_req_s = 1'b0;
    repeat (2) tick();
    chk("arst_hold_duty", duty, 0);
    chk("arst_hold_busy", busy, 0);

    reset  = 1'b0;
    edge_n = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_d = (i < 5) ? 0 : ((i < 7) ? 1 : 2);
      chk($sformatf("restart_duty[%0d]", i), duty, exp_d);
      chk($sformatf("restart_busy[%0d]", i), busy, (i >= 3) ? 1 : 0);
      chk($sformatf("restart_slow_duty[%0d]", i), duty_s, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
